// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM encoding,
// and the request legality check used in the accept cycle.
package lsu_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LD_WAIT  = 2'd1,
    S_LD_RESP  = 2'd2,
    S_ST_MERGE = 2'd3
  } lsu_state_e;

  // Illegal funct3 or an access not naturally aligned to its size.
  function automatic logic req_fault(input logic we, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic bad_f3;
    logic misaligned;
    bad_f3 = we ? (f3 > F3_SW) : ((f3 == 3'd3) || (f3[2:1] == 2'b11));
    case (f3[1:0])
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = (off != 2'd0);
      default: misaligned = 1'b0;
    endcase
    return bad_f3 || misaligned;
  endfunction
endpackage

// File: rtl/lsu_if.sv
// Pipeline request/response and data-memory port bundle for the LSU.
interface lsu_if;
  import lsu_pkg::*;

  // req_valid is sampled only when the LSU is idle; while stall=1 the pipeline
  // holds the same request, and it advances at the end of the first cycle with stall=0.
  logic            req_valid;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [4:0]      req_rd;
  logic            stall;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  logic [4:0]      resp_rd;
  logic            fault;
  logic [AW-1:0]   mem_addr;
  logic            mem_rd;
  logic            mem_wr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, mem_rdata,
    output stall, resp_valid, resp_data, resp_rd, fault,
           mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, mem_rdata,
    input  stall, resp_valid, resp_data, resp_rd, fault,
           mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane handling: load extract with sign/zero extension, and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rword_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] ld_data_o,
  output logic [XLEN-1:0] st_word_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rword_i[{off_i, 3'b000} +: 8];
    half_sel  = off_i[1] ? rword_i[31:16] : rword_i[15:0];
    ld_data_o = rword_i;
    case (funct3_i)
      F3_LB:   ld_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   ld_data_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  ld_data_o = {24'd0, byte_sel};
      F3_LHU:  ld_data_o = {16'd0, half_sel};
      default: ld_data_o = rword_i;
    endcase

    st_word_o = rword_i;
    case (funct3_i[1:0])
      2'd0:    st_word_o[{off_i, 3'b000} +: 8]     = wdata_i[7:0];
      2'd1:    st_word_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: st_word_o = wdata_i;
    endcase
  end
endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: word-wide memory access, lane extraction, and
// read-modify-write for byte/halfword stores, stalling the pipeline while busy.
module lsu
  import lsu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  lsu_if.slave       bus,
  output lsu_state_e dbg_state_o
);
  lsu_state_e      state_q, state_d;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic            accept;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] st_word;
  logic            unused_addr_hi;

  // Addresses wrap modulo the memory size; the upper bits carry no meaning here.
  assign unused_addr_hi = ^bus.req_addr[XLEN-1:AW+2];

  lsu_align u_align (
    .off_i     (off_q),
    .funct3_i  (f3_q),
    .rword_i   (bus.mem_rdata),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    resp_data_d    = resp_data_q;
    bus.stall      = 1'b0;
    bus.fault      = 1'b0;
    bus.resp_valid = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = addr_q;
    bus.mem_wdata  = '0;
    case (state_q)
      S_IDLE: begin
        bus.mem_addr = bus.req_addr[AW+1:2];
        if (bus.req_valid) begin
          if (req_fault(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
            bus.fault = 1'b1;
          end else begin
            accept = 1'b1;
            if (bus.req_we && bus.req_funct3 == F3_SW) begin
              bus.mem_wr    = 1'b1;
              bus.mem_wdata = bus.req_wdata;
            end else begin
              // Loads and sub-word stores both need the old word first.
              bus.mem_rd = 1'b1;
              bus.stall  = 1'b1;
              state_d    = bus.req_we ? S_ST_MERGE : S_LD_WAIT;
            end
          end
        end
      end
      S_LD_WAIT: begin
        bus.stall   = 1'b1;
        resp_data_d = ld_data;
        state_d     = S_LD_RESP;
      end
      S_LD_RESP: begin
        bus.resp_valid = 1'b1;
        state_d        = S_IDLE;
      end
      S_ST_MERGE: begin
        bus.mem_wr    = 1'b1;
        bus.mem_wdata = st_word;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (reset) begin
      accept         = 1'b0;
      bus.stall      = 1'b0;
      bus.fault      = 1'b0;
      bus.resp_valid = 1'b0;
      bus.mem_rd     = 1'b0;
      bus.mem_wr     = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      f3_q        <= '0;
      off_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      resp_data_q <= resp_data_d;
      if (accept) begin
        f3_q    <= bus.req_funct3;
        off_q   <= bus.req_addr[1:0];
        addr_q  <= bus.req_addr[AW+1:2];
        wdata_q <= bus.req_wdata;
        rd_q    <= bus.req_rd;
      end
    end
  end

  assign bus.resp_data = resp_data_q;
  assign bus.resp_rd   = rd_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized requests against a
// size/offset arithmetic model of RV32I loads and stores over a word memory.
module tb_lsu;
  import lsu_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  lsu_state_e dbg_state;
  int         n_vec = 0;
  int         n_err = 0;
  int         rd_pulses = 0;
  int         resp_pulses = 0;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic [31:0] rdata_q = '0;

  lsu_if bus ();

  lsu dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // Word memory: registered read, same-cycle write.
  always @(posedge clk) begin
    if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) rdata_q <= mem[bus.mem_addr];
    if (!reset) begin
      if (bus.mem_rd)     rd_pulses   <= rd_pulses + 1;
      if (bus.resp_valid) resp_pulses <= resp_pulses + 1;
    end
  end
  assign bus.mem_rdata = rdata_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    int nb;
    int sh;
    logic [31:0] v;
    nb = 1 << f3[1:0];
    sh = 32 - 8 * nb;
    v  = (w >> (8 * off)) << sh;
    return f3[2] ? (v >> sh) : 32'($signed(v) >>> sh);
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [31:0] wd,
                                            input logic [2:0] f3, input logic [1:0] off);
    int nb;
    logic [31:0] mask;
    nb   = 1 << f3[1:0];
    mask = ((nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1)) << (8 * off);
    return (w & ~mask) | ((wd << (8 * off)) & mask);
  endfunction

  // Presents one request at the current cycle and checks every cycle until the
  // LSU is ready again; leaves req_valid asserted so a following call is back-to-back.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         output logic [31:0] got);
    logic [1:0]  off;
    logic [4:0]  widx;
    int          nb;
    logic        flt;
    logic [31:0] exp_ld;
    logic [31:0] exp_st;
    off  = addr[1:0];
    widx = addr[6:2];
    nb   = 1 << f3[1:0];
    flt  = (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5)) || ((32'(off) % nb) != 0);
    exp_ld = ref_load(ref_mem[widx], f3, off);
    exp_st = ref_merge(ref_mem[widx], wdata, f3, off);
    got = '0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_rd     = rd;
    #3;
    chk("c0_fault", 32'(bus.fault), 32'(flt));
    if (flt) begin
      chk("flt_stall", 32'(bus.stall), 32'd0);
      chk("flt_rd", 32'(bus.mem_rd), 32'd0);
      chk("flt_wr", 32'(bus.mem_wr), 32'd0);
    end else if (!we) begin
      chk("ld_c0_rd", 32'(bus.mem_rd), 32'd1);
      chk("ld_c0_stall", 32'(bus.stall), 32'd1);
      chk("ld_c0_wr", 32'(bus.mem_wr), 32'd0);
      chk("ld_c0_addr", 32'(bus.mem_addr), 32'(widx));
      chk("ld_c0_rv", 32'(bus.resp_valid), 32'd0);
      tick(); #3;
      chk("ld_c1_stall", 32'(bus.stall), 32'd1);
      chk("ld_c1_rd", 32'(bus.mem_rd), 32'd0);
      chk("ld_c1_rv", 32'(bus.resp_valid), 32'd0);
      tick(); #3;
      chk("ld_c2_rv", 32'(bus.resp_valid), 32'd1);
      chk("ld_c2_stall", 32'(bus.stall), 32'd0);
      chk("ld_c2_rd", 32'(bus.mem_rd), 32'd0);
      chk("ld_c2_data", bus.resp_data, exp_ld);
      chk("ld_c2_rdst", 32'(bus.resp_rd), 32'(rd));
      got = bus.resp_data;
    end else if (f3 == 3'd2) begin
      chk("sw_wr", 32'(bus.mem_wr), 32'd1);
      chk("sw_rd", 32'(bus.mem_rd), 32'd0);
      chk("sw_stall", 32'(bus.stall), 32'd0);
      chk("sw_addr", 32'(bus.mem_addr), 32'(widx));
      chk("sw_wdata", bus.mem_wdata, wdata);
      ref_mem[widx] = wdata;
    end else begin
      chk("st_c0_rd", 32'(bus.mem_rd), 32'd1);
      chk("st_c0_stall", 32'(bus.stall), 32'd1);
      chk("st_c0_wr", 32'(bus.mem_wr), 32'd0);
      chk("st_c0_addr", 32'(bus.mem_addr), 32'(widx));
      tick(); #3;
      chk("st_c1_wr", 32'(bus.mem_wr), 32'd1);
      chk("st_c1_stall", 32'(bus.stall), 32'd0);
      chk("st_c1_rd", 32'(bus.mem_rd), 32'd0);
      chk("st_c1_addr", 32'(bus.mem_addr), 32'(widx));
      chk("st_c1_wdata", bus.mem_wdata, exp_st);
      ref_mem[widx] = exp_st;
    end
    tick();
    chk("mem_word", mem[widx], ref_mem[widx]);
  endtask

  task automatic idle_cycle();
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom_range(0, 1));
    bus.req_funct3 = 3'($urandom_range(0, 7));
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_rd     = 5'($urandom_range(0, 31));
    #3;
    chk("idle_quiet", {28'd0, bus.stall, bus.mem_rd, bus.mem_wr, bus.fault}, 32'd0);
    chk("idle_rv", 32'(bus.resp_valid), 32'd0);
    tick();
  endtask

  initial begin
    logic [31:0] got;
    int          rd0;
    int          rv0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_SW;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h1;
    bus.req_rd     = 5'd0;
    repeat (3) tick();
    #2;
    chk("rst_forced_wr", 32'(bus.mem_wr), 32'd0);
    chk("rst_forced_rd", 32'(bus.mem_rd), 32'd0);
    tick();
    reset        = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    #3;
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_flags", {27'd0, bus.stall, bus.resp_valid, bus.fault, bus.mem_rd, bus.mem_wr}, 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_resp_rd", 32'(bus.resp_rd), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    tick();

    // Fill memory through the LSU itself.
    for (int i = 0; i < 32; i++)
      run_req(1'b1, F3_SW, 32'(i * 4), (i == 1) ? 32'h8899_AABB : $urandom, 5'd0, got);
    run_req(1'b1, F3_SW, 32'h08, 32'hDEAD_BEEF, 5'd0, got);
    chk("sw_dead", mem[2], 32'hDEAD_BEEF);

    run_req(1'b0, F3_LB, 32'h07, 32'h0, 5'd3, got);   chk("lb_07", got, 32'hFFFF_FF88);
    run_req(1'b0, F3_LBU, 32'h07, 32'h0, 5'd4, got);  chk("lbu_07", got, 32'h0000_0088);
    run_req(1'b0, F3_LH, 32'h06, 32'h0, 5'd5, got);   chk("lh_06", got, 32'hFFFF_8899);
    run_req(1'b0, F3_LHU, 32'h04, 32'h0, 5'd31, got); chk("lhu_04", got, 32'h0000_AABB);

    run_req(1'b1, F3_SB, 32'h05, 32'h123, 5'd0, got);
    chk("sb_05", mem[1], 32'h8899_23BB);
    run_req(1'b1, F3_SW, 32'h04, 32'h8899_AABB, 5'd0, got);
    run_req(1'b1, F3_SH, 32'h06, 32'h1234, 5'd0, got);
    chk("sh_06", mem[1], 32'h1234_AABB);

    run_req(1'b0, F3_LW, 32'h06, 32'h0, 5'd1, got);
    run_req(1'b1, F3_SH, 32'h05, 32'hFFFF, 5'd0, got);
    run_req(1'b0, 3'd3, 32'h00, 32'h0, 5'd1, got);
    chk("flt_mem1", mem[1], 32'h1234_AABB);

    // Reset while the read-modify-write is in flight must drop the write.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_SB;
    bus.req_addr   = 32'h04;
    bus.req_wdata  = 32'hFF;
    #3;
    chk("abort_c0_rd", 32'(bus.mem_rd), 32'd1);
    tick();
    reset = 1'b1;
    #3;
    chk("abort_merge_wr", 32'(bus.mem_wr), 32'd0);
    tick();
    reset = 1'b0;
    bus.req_valid = 1'b0;
    #3;
    chk("abort_state", 32'(dbg_state), 32'(S_IDLE));
    chk("abort_mem1", mem[1], ref_mem[1]);
    tick();

    rd0 = rd_pulses;
    rv0 = resp_pulses;
    run_req(1'b0, F3_LW, 32'h04, 32'h0, 5'd7, got); chk("b2b_lw0", got, ref_mem[1]);
    run_req(1'b0, F3_LW, 32'h08, 32'h0, 5'd8, got); chk("b2b_lw1", got, ref_mem[2]);
    idle_cycle();
    chk("b2b_rd_pulses", 32'(rd_pulses - rd0), 32'd2);
    chk("b2b_rv_pulses", 32'(resp_pulses - rv0), 32'd2);

    repeat (300) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      else run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   5'($urandom_range(0, 31)), got);
    end
    idle_cycle();
    for (int i = 0; i < 32; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
